axi_lite_arbiter: RTL and testbench

- Two-master, one-slave AXI4-Lite arbiter.
- Lets the instruction-fetch master (m0) and the load/store master (m1) share a single AXI4-Lite slave port, such as the UART or SRAM model.
- Grants the bus to one master for one complete transaction (address through response), using round-robin between masters.
- Sits between the core's memory-access units and the slave-side bus.

---
 rtl/axi_lite_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-master, one-slave AXI4-Lite round-robin arbiter
// One whole transaction (address through response) is granted at a time.
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_araddr,
  input  logic                    m0_arvalid,
  output logic                    m0_arready,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic [1:0]              m0_rresp,
  output logic                    m0_rvalid,
  input  logic                    m0_rready,
  input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic                    m0_awvalid,
  output logic                    m0_awready,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic                    m0_wvalid,
  output logic                    m0_wready,
  output logic [1:0]              m0_bresp,
  output logic                    m0_bvalid,
  input  logic                    m0_bready,
  input  logic [ADDR_WIDTH-1:0]   m1_araddr,
  input  logic                    m1_arvalid,
  output logic                    m1_arready,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [1:0]              m1_rresp,
  output logic                    m1_rvalid,
  input  logic                    m1_rready,
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic                    m1_awvalid,
  output logic                    m1_awready,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                    m1_wvalid,
  output logic                    m1_wready,
  output logic [1:0]              m1_bresp,
  output logic                    m1_bvalid,
  input  logic                    m1_bready,
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  output logic                    s_arvalid,
  input  logic                    s_arready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic                    s_rvalid,
  output logic                    s_rready,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic                    s_awvalid,
  input  logic                    s_awready,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_wvalid,
  input  logic                    s_wready,
  input  logic [1:0]              s_bresp,
  input  logic                    s_bvalid,
  output logic                    s_bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP} state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt, last_grant;
  logic   aw_done, w_done, aw_done_nxt, w_done_nxt;
  logic   req0, req1, arb_take, aw_fin, w_fin;

  logic                    ar_rdy, r_vld, aw_rdy, w_rdy, b_vld;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp, b_resp;

  // Granted master's request side, selected once so the FSM is master-agnostic
  logic [ADDR_WIDTH-1:0]   g_araddr, g_awaddr;
  logic [DATA_WIDTH-1:0]   g_wdata;
  logic [DATA_WIDTH/8-1:0] g_wstrb;
  logic                    g_arvalid, g_awvalid, g_wvalid, g_rready, g_bready;

  assign g_araddr  = grant ? m1_araddr  : m0_araddr;
  assign g_arvalid = grant ? m1_arvalid : m0_arvalid;
  assign g_rready  = grant ? m1_rready  : m0_rready;
  assign g_awaddr  = grant ? m1_awaddr  : m0_awaddr;
  assign g_awvalid = grant ? m1_awvalid : m0_awvalid;
  assign g_wdata   = grant ? m1_wdata   : m0_wdata;
  assign g_wstrb   = grant ? m1_wstrb   : m0_wstrb;
  assign g_wvalid  = grant ? m1_wvalid  : m0_wvalid;
  assign g_bready  = grant ? m1_bready  : m0_bready;

  assign req0     = m0_arvalid | m0_awvalid;
  assign req1     = m1_arvalid | m1_awvalid;
  assign arb_take = (state == IDLE) && (req0 || req1);
  assign aw_fin   = aw_done | (g_awvalid & s_awready);
  assign w_fin    = w_done  | (g_wvalid  & s_wready);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    s_araddr    = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    s_awaddr    = '0;
    s_awvalid   = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_wvalid    = 1'b0;
    s_bready    = 1'b0;
    ar_rdy      = 1'b0;
    r_vld       = 1'b0;
    r_data      = '0;
    r_resp      = 2'b00;
    aw_rdy      = 1'b0;
    w_rdy       = 1'b0;
    b_vld       = 1'b0;
    b_resp      = 2'b00;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_nxt = (req0 && req1) ? ~last_grant : req1;
          state_nxt = (grant_nxt ? m1_arvalid : m0_arvalid) ? RD_ADDR : WR_REQ;
        end
      end
      RD_ADDR: begin
        s_araddr  = g_araddr;
        s_arvalid = g_arvalid;
        ar_rdy    = s_arready;
        if (g_arvalid && s_arready) state_nxt = RD_RESP;
      end
      RD_RESP: begin
        r_data   = s_rdata;
        r_resp   = s_rresp;
        r_vld    = s_rvalid;
        s_rready = g_rready;
        if (s_rvalid && g_rready) state_nxt = IDLE;
      end
      WR_REQ: begin
        // AW and W complete independently; a finished channel stops forwarding
        s_awaddr  = g_awaddr;
        s_awvalid = g_awvalid & ~aw_done;
        aw_rdy    = s_awready & ~aw_done;
        s_wdata   = g_wdata;
        s_wstrb   = g_wstrb;
        s_wvalid  = g_wvalid & ~w_done;
        w_rdy     = s_wready & ~w_done;
        if (aw_fin && w_fin) begin
          state_nxt   = WR_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = aw_fin;
          w_done_nxt  = w_fin;
        end
      end
      WR_RESP: begin
        b_resp   = s_bresp;
        b_vld    = s_bvalid;
        s_bready = g_bready;
        if (s_bvalid && g_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (arb_take) last_grant <= grant_nxt;
    end
  end

  // Non-granted master sees all-zero responses and readies
  assign m0_arready = ~grant & ar_rdy;
  assign m1_arready =  grant & ar_rdy;
  assign m0_rvalid  = ~grant & r_vld;
  assign m1_rvalid  =  grant & r_vld;
  assign m0_rdata   = grant ? '0 : r_data;
  assign m1_rdata   = grant ? r_data : '0;
  assign m0_rresp   = grant ? 2'b00 : r_resp;
  assign m1_rresp   = grant ? r_resp : 2'b00;
  assign m0_awready = ~grant & aw_rdy;
  assign m1_awready =  grant & aw_rdy;
  assign m0_wready  = ~grant & w_rdy;
  assign m1_wready  =  grant & w_rdy;
  assign m0_bvalid  = ~grant & b_vld;
  assign m1_bvalid  =  grant & b_vld;
  assign m0_bresp   = grant ? 2'b00 : b_resp;
  assign m1_bresp   = grant ? b_resp : 2'b00;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - scoreboard bench for axi_lite_arbiter
module tb_axi_lite_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0][31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [1:0][3:0]  m_wstrb;
  logic [1:0][1:0]  m_rresp, m_bresp;
  logic [1:0]       m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]       m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic [255:0] outs;
  assign outs = {69'd0, m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready, m_bvalid,
                 m_bresp, s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata,
                 s_wstrb, s_bready};

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;
  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push(input int m, input bit wr, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.m = m; e.wr = wr; e.data = d; e.resp = r;
    sbq.push_back(e);
  endtask

  task automatic got(input int m, input bit wr, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    if (sbq.size() == 0) begin
      flag($sformatf("unexpected_resp m%0d wr=%0d resp=%0h", m, wr, r));
    end else begin
      e = sbq.pop_front();
      chk("resp_master", m, e.m);
      chk("resp_kind", wr, e.wr);
      if (!e.wr) chk("rdata", d, e.data);
      chk("resp_code", r, e.resp);
    end
  endtask

  // Monitor: pops the scoreboard on every master response handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int m = 0; m < 2; m++) begin
          if (m_rvalid[m] && m_rready[m]) got(m, 1'b0, m_rdata[m], m_rresp[m]);
          if (m_bvalid[m] && m_bready[m]) got(m, 1'b1, 32'd0, m_bresp[m]);
          if ((m_arready[m] && !m_arvalid[m]) || (m_awready[m] && !m_awvalid[m]) ||
              (m_wready[m] && !m_wvalid[m]))
            flag($sformatf("ready_without_request m%0d", m));
        end
        if ((m_rvalid[0] | m_bvalid[0] | m_arready[0] | m_awready[0] | m_wready[0]) &&
            (m_rvalid[1] | m_bvalid[1] | m_arready[1] | m_awready[1] | m_wready[1]))
          flag("both_masters_active");
      end
    end
  end

  // Slave model: programmable accept/response delays, decodes 0xb... as bad
  int ar_dly = 0, r_dly = 1, aw_dly = 0, w_dly = 0, b_dly = 1;
  int aw_count = 0, w_count = 0;
  logic [31:0] got_awaddr, got_wdata;
  logic [3:0]  got_wstrb;

  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, arv, awv, wv;
    bit rd_pend, b_pend, aw_got, w_got;
    int ar_cnt, rd_cnt, aw_cnt, w_cnt, b_cnt;
    logic [31:0] ar_a, aw_a, w_d, rd_addr;
    logic [3:0]  w_s;
    logic [1:0]  b_r;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; b_r = 0; rd_addr = 0;
    ar_cnt = 0; rd_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      ar_hs = s_arvalid & s_arready; r_hs = s_rvalid & s_rready;
      aw_hs = s_awvalid & s_awready; w_hs = s_wvalid & s_wready; b_hs = s_bvalid & s_bready;
      arv = s_arvalid; awv = s_awvalid; wv = s_wvalid;
      ar_a = s_araddr; aw_a = s_awaddr; w_d = s_wdata; w_s = s_wstrb;
      @(posedge clk);
      #1;
      if (reset) begin
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      if (ar_hs) begin
        s_arready = 0; ar_cnt = 0; rd_pend = 1; rd_cnt = r_dly; rd_addr = ar_a;
      end else if (arv && !s_arready) begin
        if (ar_cnt >= ar_dly) s_arready = 1; else ar_cnt++;
      end
      if (r_hs) begin
        s_rvalid = 0; s_rdata = 0; s_rresp = 0;
      end
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          rd_pend = 0; s_rvalid = 1;
          if (rd_addr[31:28] == 4'hb) begin
            s_rdata = 0; s_rresp = SLVERR;
          end else begin
            s_rdata = {16'd0, rd_addr[15:0]} + 32'h41; s_rresp = OKAY;
          end
        end else rd_cnt--;
      end
      if (aw_hs) begin
        s_awready = 0; aw_cnt = 0; aw_got = 1; aw_count++; got_awaddr = aw_a;
        b_r = (aw_a[31:28] == 4'hb) ? SLVERR : OKAY;
      end else if (awv && !s_awready) begin
        if (aw_cnt >= aw_dly) s_awready = 1; else aw_cnt++;
      end
      if (w_hs) begin
        s_wready = 0; w_cnt = 0; w_got = 1; w_count++; got_wdata = w_d; got_wstrb = w_s;
      end else if (wv && !s_wready) begin
        if (w_cnt >= w_dly) s_wready = 1; else w_cnt++;
      end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1; b_cnt = b_dly;
      end
      if (b_hs) begin
        s_bvalid = 0; s_bresp = 0;
      end
      if (b_pend) begin
        if (b_cnt == 0) begin
          b_pend = 0; s_bvalid = 1; s_bresp = b_r;
        end else b_cnt--;
      end
    end
  end

  // Master drivers: start and return at posedge+1
  task automatic rd(input int m, input logic [31:0] a);
    int n = 0;
    m_araddr[m] = a; m_arvalid[m] = 1'b1;
    forever begin
      @(negedge clk);
      n++;
      if (m_arvalid[m] && m_arready[m]) begin
        @(posedge clk); #1;
        m_arvalid[m] = 1'b0;
        return;
      end
      if (n > 300) begin
        flag($sformatf("ar_timeout m%0d", m));
        m_arvalid[m] = 1'b0;
        return;
      end
    end
  endtask

  task automatic wr(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit awd = 0, wd = 0, haw, hw;
    int n = 0;
    m_awaddr[m] = a; m_wdata[m] = d; m_wstrb[m] = s;
    m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1;
    while (!(awd && wd)) begin
      @(negedge clk);
      n++;
      haw = m_awvalid[m] & m_awready[m];
      hw  = m_wvalid[m] & m_wready[m];
      if (haw || hw) begin
        @(posedge clk); #1;
        if (haw) begin m_awvalid[m] = 1'b0; awd = 1; end
        if (hw)  begin m_wvalid[m]  = 1'b0; wd  = 1; end
      end else if (n > 300) begin
        flag($sformatf("aw_w_timeout m%0d", m));
        m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      flag($sformatf("resp_timeout pending=%0d", sbq.size()));
      sbq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rd_test(input int m, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    push(m, 1'b0, d, r);
    rd(m, a);
    drain();
  endtask

  task automatic wr_test(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int awd, input int wd, input logic [1:0] r);
    aw_dly = awd; w_dly = wd; aw_count = 0; w_count = 0;
    push(m, 1'b1, 32'd0, r);
    wr(m, a, d, s);
    drain();
    chk("slave_aw_count", aw_count, 1);
    chk("slave_w_count", w_count, 1);
    chk("slave_awaddr", got_awaddr, a);
    chk("slave_wdata", got_wdata, d);
    chk("slave_wstrb", got_wstrb, s);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
    m_rready = 2'b11; m_bready = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs, 256'd0);
    @(posedge clk); #1 reset = 1'b0;

    r_dly = 3;
    rd_test(0, 32'ha000_0000, 32'h0000_0041, OKAY);

    // Ties out of reset go to m0, then alternate
    pulse_reset();
    r_dly = 1;
    push(0, 1'b0, 32'h45, OKAY); push(1, 1'b0, 32'h51, OKAY);
    fork rd(0, 32'ha000_0004); rd(1, 32'ha000_0010); join
    drain();
    push(0, 1'b0, 32'h61, OKAY); push(1, 1'b0, 32'h71, OKAY);
    fork rd(0, 32'ha000_0020); rd(1, 32'ha000_0030); join
    drain();
    rd_test(0, 32'ha000_0080, 32'hc1, OKAY);
    push(1, 1'b0, 32'hd1, OKAY); push(0, 1'b0, 32'hd5, OKAY);
    fork rd(0, 32'ha000_0094); rd(1, 32'ha000_0090); join
    drain();

    // AW before W, W before AW, same cycle, bad address
    wr_test(1, 32'ha000_0000, 32'h0000_0048, 4'hf, 0, 2, OKAY);
    wr_test(0, 32'ha000_0008, 32'hdead_beef, 4'h5, 3, 0, OKAY);
    wr_test(0, 32'ha000_000c, 32'h0000_0001, 4'h1, 0, 0, OKAY);
    wr_test(1, 32'hb000_0004, 32'h0000_0002, 4'hf, 1, 1, SLVERR);

    // Same master read + write: read first, write after re-arbitration
    aw_dly = 0; w_dly = 0; aw_count = 0; w_count = 0;
    push(0, 1'b0, 32'h81, OKAY); push(0, 1'b1, 32'd0, OKAY);
    fork rd(0, 32'ha000_0040); wr(0, 32'ha000_0044, 32'h0000_1234, 4'h3); join
    drain();
    chk("rw_w_count", w_count, 1);
    chk("rw_wdata", got_wdata, 32'h0000_1234);

    rd_test(1, 32'hb000_0000, 32'h0, SLVERR);

    // Reset while waiting for rvalid: transaction abandoned, no response
    r_dly = 10;
    rd(0, 32'ha000_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("mid_reset_outputs", outs, 256'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    r_dly = 1;
    rd_test(0, 32'ha000_0008, 32'h49, OKAY);

    repeat (20) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
